// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard sequencer for the 5-stage core.
// Turns ID/EX/MEM hazard information into per-stage enable, hold, bubble and
// flush controls. Handles the hazards operand forwarding cannot resolve:
// load-use interlock, taken-branch redirect, multi-cycle mul/div wait and
// data-memory wait. Control outputs are combinational from state and inputs;
// state, the mul/div wait counter and the performance counters are registered.
module hazard_ctrl_unit #(
  parameter int MD_TIMEOUT = 64,  // max cycles spent in MD_WAIT before abort (>=2)
  parameter int CNT_W      = 16   // width of the saturating performance counters
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             MemRead_ex,
  input  logic             branch_taken_ex,
  input  logic             md_start_ex,
  input  logic             md_done,
  input  logic             dmem_req_mem,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic             ex_mem_bubble,
  output logic             md_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Wide enough to hold MD_TIMEOUT-1 with headroom.
  localparam int MD_CNT_W = $clog2(MD_TIMEOUT) + 1;

  state_t              state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                load_use;
  logic                mem_stall;
  logic                md_expired;
  logic                flush_evt;

  // The ID instruction needs a register a load in EX has not produced yet.
  // x0 is never a real dependency.
  assign load_use = MemRead_ex && (rd_ex != 5'd0) &&
                    ((use_rs1_id && (rs1_id == rd_ex)) ||
                     (use_rs2_id && (rs2_id == rd_ex)));

  // In RUN a stall needs an outstanding request; once in MEM_WAIT the access
  // is known to be in flight, so only the ack matters.
  assign mem_stall = (state_q == MEM_WAIT) ? !dmem_ack : (dmem_req_mem && !dmem_ack);

  assign md_expired = (md_cnt_q == MD_CNT_W'(MD_TIMEOUT - 1));

  assign state = state_q;

  // Next-state and control decode; RUN and MEM_WAIT share one priority chain.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_hold   = 1'b0;
    ex_mem_bubble = 1'b0;
    md_timeout    = 1'b0;
    flush_evt     = 1'b0;
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;

    case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          // Full freeze: nothing may advance past MEM.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_hold  = 1'b1;
          ex_mem_hold = 1'b1;
          state_d     = MEM_WAIT;
        end else if (md_start_ex && !md_done) begin
          // Hold the mul/div in EX and feed NOPs downstream while it works.
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_hold    = 1'b1;
          ex_mem_bubble = 1'b1;
          md_cnt_d      = MD_CNT_W'(1);
          state_d       = MD_WAIT;
        end else if (branch_taken_ex) begin
          // Squash the wrong-path IF and ID instructions; a load-use on the
          // squashed ID instruction is therefore irrelevant.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_evt    = 1'b1;
          state_d      = RUN;
        end else if (load_use) begin
          // One-cycle interlock; the load moves to MEM and the hazard clears.
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          state_d      = RUN;
        end else begin
          state_d = RUN;
        end
      end

      MD_WAIT: begin
        if (md_done) begin
          state_d  = RUN;
          md_cnt_d = '0;
        end else if (md_expired) begin
          // Abort: release the pipeline exactly as a normal completion would.
          md_timeout = 1'b1;
          state_d    = RUN;
          md_cnt_d   = '0;
        end else begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_hold    = 1'b1;
          ex_mem_bubble = 1'b1;
          md_cnt_d      = md_cnt_q + MD_CNT_W'(1);
        end
      end

      default: begin
        state_d  = RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  // FSM state and mul/div wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from values sampled at the same clock edge.
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Saturating performance counters: stalled cycles and branch flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (flush_evt && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit.
// Single-cycle RUN decisions come from a vector table; multi-cycle waits,
// timeout, counter saturation and mid-stall reset are hand-written sequences.
// Expected observations are queued when stimulus is driven and compared when
// the DUT outputs are sampled on the falling edge.
module tb_hazard_ctrl_unit;

  localparam int MD_TO = 8;
  localparam int CW    = 4;

  // Control vector bit order:
  // {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble,
  //  ex_mem_hold, ex_mem_bubble, md_timeout}
  localparam logic [7:0] C_NORM = 8'b1100_0000;
  localparam logic [7:0] C_LU   = 8'b0000_1000;
  localparam logic [7:0] C_BR   = 8'b1110_1000;
  localparam logic [7:0] C_MEM  = 8'b0001_0100;
  localparam logic [7:0] C_MD   = 8'b0001_0010;
  localparam logic [7:0] C_TO   = 8'b1100_0001;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MD  = 2'd1;
  localparam logic [1:0] S_MEM = 2'd2;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       memread;
    logic       br;
    logic       md_start;
    logic       md_done;
    logic       dreq;
    logic       dack;
  } stim_t;

  typedef struct packed {
    logic [7:0]    ctrl;
    logic [1:0]    st;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } obs_t;

  typedef struct {
    stim_t      in;
    logic [7:0] ctrl;
    logic [1:0] st;
    string      name;
  } vec_t;

  logic          clk, rst_n;
  logic [4:0]    rs1_id, rs2_id, rd_ex;
  logic          use_rs1_id, use_rs2_id, MemRead_ex, branch_taken_ex;
  logic          md_start_ex, md_done, dmem_req_mem, dmem_ack;
  logic          pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble;
  logic          ex_mem_hold, ex_mem_bubble, md_timeout;
  logic [1:0]    state;
  logic [CW-1:0] stall_count, flush_count;

  hazard_ctrl_unit #(.MD_TIMEOUT(MD_TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .MemRead_ex(MemRead_ex),
    .branch_taken_ex(branch_taken_ex),
    .md_start_ex(md_start_ex), .md_done(md_done),
    .dmem_req_mem(dmem_req_mem), .dmem_ack(dmem_ack),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_bubble(id_ex_bubble),
    .ex_mem_hold(ex_mem_hold), .ex_mem_bubble(ex_mem_bubble),
    .md_timeout(md_timeout), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  obs_t          exp_q[$];
  string         name_q[$];
  logic [CW-1:0] exp_stall = '0;
  logic [CW-1:0] exp_flush = '0;

  // flags = {memread, br, md_start, md_done, dreq, dack}
  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2,
                               input logic [4:0] rd, input logic [5:0] flags);
    stim_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.use1 = u1; s.use2 = u2; s.rd = rd;
    {s.memread, s.br, s.md_start, s.md_done, s.dreq, s.dack} = flags;
    return s;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.ctrl  = {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble,
               ex_mem_hold, ex_mem_bubble, md_timeout};
    o.st    = state;
    o.stall = stall_count;
    o.flush = flush_count;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input stim_t s);
    rs1_id = s.rs1; rs2_id = s.rs2; use_rs1_id = s.use1; use_rs2_id = s.use2;
    rd_ex = s.rd; MemRead_ex = s.memread; branch_taken_ex = s.br;
    md_start_ex = s.md_start; md_done = s.md_done;
    dmem_req_mem = s.dreq; dmem_ack = s.dack;
  endtask

  // One clock cycle: drive after the rising edge, queue the expectation
  // (counters reflect earlier cycles), compare on the falling edge.
  task automatic step(input stim_t s, input logic [7:0] ctrl, input logic [1:0] st,
                      input string name);
    obs_t e;
    obs_t a;
    string n;
    @(posedge clk);
    #1;
    drive(s);
    e.ctrl = ctrl; e.st = st; e.stall = exp_stall; e.flush = exp_flush;
    exp_q.push_back(e);
    name_q.push_back(name);
    if (!ctrl[7]) exp_stall = sat_inc(exp_stall);
    if (ctrl[5])  exp_flush = sat_inc(exp_flush);
    @(negedge clk);
    e = exp_q.pop_front();
    n = name_q.pop_front();
    a = observe();
    check(n, 32'(a), 32'(e));
  endtask

  vec_t  vecs[12];
  stim_t z, md, mdd, m_lu, m_ack_lu, brv;
  obs_t  o;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    z        = mk(0, 0, 0, 0, 0, 6'b000000);
    md       = mk(0, 0, 0, 0, 0, 6'b001000);
    mdd      = mk(0, 0, 0, 0, 0, 6'b001100);
    m_lu     = mk(0, 5, 0, 1, 5, 6'b100010);
    m_ack_lu = mk(0, 5, 0, 1, 5, 6'b100011);
    brv      = mk(0, 0, 0, 0, 0, 6'b010000);

    vecs[0]  = '{mk(0, 0, 0, 0, 0, 6'b000000), C_NORM, S_RUN, "idle"};
    vecs[1]  = '{mk(0, 5, 0, 1, 5, 6'b100000), C_LU,   S_RUN, "lu_rs2"};
    vecs[2]  = '{mk(0, 0, 1, 1, 0, 6'b100000), C_NORM, S_RUN, "lu_rd_zero"};
    vecs[3]  = '{mk(7, 0, 1, 0, 7, 6'b100000), C_LU,   S_RUN, "lu_rs1"};
    vecs[4]  = '{mk(7, 7, 0, 0, 7, 6'b100000), C_NORM, S_RUN, "lu_no_use"};
    vecs[5]  = '{mk(7, 7, 1, 1, 7, 6'b000000), C_NORM, S_RUN, "match_no_load"};
    vecs[6]  = '{mk(0, 5, 0, 1, 5, 6'b110000), C_BR,   S_RUN, "branch_over_lu"};
    vecs[7]  = '{mk(0, 0, 0, 0, 0, 6'b010000), C_BR,   S_RUN, "branch"};
    vecs[8]  = '{mk(0, 0, 0, 0, 0, 6'b001100), C_NORM, S_RUN, "md_same_cycle_done"};
    vecs[9]  = '{mk(0, 0, 0, 0, 0, 6'b000011), C_NORM, S_RUN, "dmem_same_cycle_ack"};
    vecs[10] = '{mk(3, 0, 1, 0, 3, 6'b100011), C_LU,   S_RUN, "dmem_ack_with_lu"};
    vecs[11] = '{mk(0, 0, 0, 0, 0, 6'b011100), C_BR,   S_RUN, "md_done_then_branch"};

    // Reset state with all inputs low.
    rst_n = 1'b0;
    drive(z);
    #12;
    o = observe();
    check("reset_state", 32'(o), 32'({C_NORM, S_RUN, {CW{1'b0}}, {CW{1'b0}}}));
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle RUN decisions.
    for (int i = 0; i < 12; i++)
      step(vecs[i].in, vecs[i].ctrl, vecs[i].st, vecs[i].name);

    // Mul/div completing on the fifth MD_WAIT cycle.
    step(md, C_MD, S_RUN, "md_enter");
    for (int i = 0; i < 4; i++) step(md, C_MD, S_MD, "md_wait");
    step(mdd, C_NORM, S_MD, "md_done_release");
    step(z, C_NORM, S_RUN, "md_after_done");

    // Mul/div never completing: abort pulse on the eighth cycle, then no more.
    step(md, C_MD, S_RUN, "to_enter");
    for (int i = 0; i < MD_TO - 2; i++) step(md, C_MD, S_MD, "to_wait");
    step(md, C_TO, S_MD, "to_pulse");
    step(z, C_NORM, S_RUN, "to_after_1");
    step(z, C_NORM, S_RUN, "to_after_2");

    // Completion on the timeout cycle wins and suppresses the pulse.
    step(md, C_MD, S_RUN, "done_vs_to_enter");
    for (int i = 0; i < MD_TO - 2; i++) step(md, C_MD, S_MD, "done_vs_to_wait");
    step(mdd, C_NORM, S_MD, "done_vs_to_release");
    step(z, C_NORM, S_RUN, "done_vs_to_after");

    // Data-memory wait with a pending load-use resolved on the ack cycle.
    step(m_lu, C_MEM, S_RUN, "mem_enter");
    step(m_lu, C_MEM, S_MEM, "mem_wait_1");
    step(m_lu, C_MEM, S_MEM, "mem_wait_2");
    step(m_ack_lu, C_LU, S_MEM, "mem_ack_lu");
    step(z, C_NORM, S_RUN, "mem_after");

    // Ack cycle that starts a mul/div moves straight to MD_WAIT.
    step(mk(0, 0, 0, 0, 0, 6'b000010), C_MEM, S_RUN, "mem2_enter");
    step(mk(0, 0, 0, 0, 0, 6'b001011), C_MD, S_MEM, "mem2_ack_md");
    step(mdd, C_NORM, S_MD, "mem2_md_done");
    step(z, C_NORM, S_RUN, "mem2_after");

    // Memory wait outranks a branch; the branch is taken on the ack cycle.
    step(mk(0, 0, 0, 0, 0, 6'b010010), C_MEM, S_RUN, "mem3_over_branch");
    step(mk(0, 0, 0, 0, 0, 6'b010011), C_BR, S_MEM, "mem3_ack_branch");
    step(z, C_NORM, S_RUN, "mem3_after");

    // Drive the flush counter into saturation.
    for (int i = 0; i < 12; i++) step(brv, C_BR, S_RUN, "flush_sat");
    step(z, C_NORM, S_RUN, "counters_saturated");

    // Asynchronous reset in the middle of a memory wait.
    step(m_lu, C_MEM, S_RUN, "rst_mem_enter");
    step(m_lu, C_MEM, S_MEM, "rst_mem_wait");
    #2;
    rst_n = 1'b0;
    #1;
    o = observe();
    check("rst_async_state_cnt", 32'({o.st, o.stall, o.flush}),
          32'({S_RUN, {CW{1'b0}}, {CW{1'b0}}}));
    drive(z);
    #1;
    o = observe();
    check("rst_async_ctrl", 32'(o.ctrl), 32'(C_NORM));
    @(negedge clk);
    rst_n = 1'b1;
    exp_stall = '0;
    exp_flush = '0;
    step(z, C_NORM, S_RUN, "after_reset");
    step(z, C_NORM, S_RUN, "after_reset_2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
